// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, fetch state encoding
// and small decode helpers used by the fetch stage and its IF/ID register.
package cpu_pkg;

    // Instruction word field positions (16-bit word)
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int RD_HI  = 2;
    localparam int RD_LO  = 0;

    // Opcode bit that marks a two-word (immediate) instruction
    localparam int TWO_WORD_BIT = 6;

    // Default halt opcode
    localparam logic [6:0] HLT_OPC = 7'h01;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        FETCH_IMM = 2'd1,
        HALT      = 2'd2
    } fetch_state_e;

    // True when the opcode announces a second (immediate) word
    function automatic logic is_two_word(input logic [6:0] opc);
        return opc[TWO_WORD_BIT];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Holds one decoded instruction for the decode
// stage. flush (highest priority) zeroes every field, load captures a new
// instruction and marks it valid, otherwise the contents are held.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [6:0]        d_opcode,
    input  logic [2:0]        d_rsrc1,
    input  logic [2:0]        d_rsrc2,
    input  logic [2:0]        d_rdst,
    input  logic [15:0]       d_imm,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [ADDR_W-1:0] d_pc_next,
    output logic              valid,
    output logic [6:0]        opcode,
    output logic [2:0]        rsrc1,
    output logic [2:0]        rsrc2,
    output logic [2:0]        rdst,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    // Register with async clear, synchronous flush, load or hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            opcode  <= '0;
            rsrc1   <= '0;
            rsrc2   <= '0;
            rdst    <= '0;
            imm     <= '0;
            pc      <= '0;
            pc_next <= '0;
        end else if (flush) begin
            valid   <= 1'b0;
            opcode  <= '0;
            rsrc1   <= '0;
            rsrc2   <= '0;
            rdst    <= '0;
            imm     <= '0;
            pc      <= '0;
            pc_next <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            opcode  <= d_opcode;
            rsrc1   <= d_rsrc1;
            rsrc2   <= d_rsrc2;
            rdst    <= d_rdst;
            imm     <= d_imm;
            pc      <= d_pc;
            pc_next <= d_pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory
// combinationally, assembles two-word instructions and feeds IF/ID.
//
// Flow control: if_valid marks a real instruction in IF/ID. There is no
// ready signal; downstream back-pressure is the stall input. While stall=1
// (and redirect=0) the PC, FSM, held word and IF/ID all keep their values,
// so an instruction presented with if_valid=1 stays presented until the
// first unstalled edge. redirect overrides stall and flushes IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [6:0]      HLT_OPCODE = HLT_OPC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic              if_valid,
    output logic [6:0]        if_opcode,
    output logic [2:0]        if_rsrc1,
    output logic [2:0]        if_rsrc2,
    output logic [2:0]        if_rdst,
    output logic [15:0]       if_imm,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       hold_word_q, hold_word_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

    logic              load;
    logic              flush;
    logic [15:0]       dec_word;
    logic [15:0]       dec_imm;
    logic [ADDR_W-1:0] dec_pc;
    logic [ADDR_W-1:0] dec_pc_next;
    logic [6:0]        word_opc;

    assign pc_inc    = pc_q + 1'b1;
    assign imem_addr = pc_q;
    assign word_opc  = imem_data[OPC_HI:OPC_LO];
    assign halted    = (state_q == HALT);
    assign dbg_state = state_q;

    // PC, FSM state and held first word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            hold_word_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // Next-state, PC update and IF/ID load/flush selection
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_word_d = hold_word_q;
        hold_pc_d   = hold_pc_q;
        load        = 1'b0;
        flush       = 1'b0;
        dec_word    = imem_data;
        dec_imm     = '0;
        dec_pc      = pc_q;
        dec_pc_next = pc_inc;

        if (redirect) begin
            pc_d        = redirect_pc;
            state_d     = FETCH;
            hold_word_d = '0;
            flush       = 1'b1;
        end else if (!stall) begin
            case (state_q)
                FETCH: begin
                    pc_d = pc_inc;
                    if (word_opc == HLT_OPCODE) begin
                        // HLT is presented once, then fetch parks
                        load    = 1'b1;
                        state_d = HALT;
                    end else if (is_two_word(word_opc)) begin
                        // Keep the first word; decode sees a bubble
                        hold_word_d = imem_data;
                        hold_pc_d   = pc_q;
                        flush       = 1'b1;
                        state_d     = FETCH_IMM;
                    end else begin
                        load = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    dec_word = hold_word_q;
                    dec_imm  = imem_data;
                    dec_pc   = hold_pc_q;
                    load     = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = FETCH;
                end
                HALT: begin
                    flush = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                    flush   = 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .flush     (flush),
        .d_opcode  (dec_word[OPC_HI:OPC_LO]),
        .d_rsrc1   (dec_word[RS1_HI:RS1_LO]),
        .d_rsrc2   (dec_word[RS2_HI:RS2_LO]),
        .d_rdst    (dec_word[RD_HI:RD_LO]),
        .d_imm     (dec_imm),
        .d_pc      (dec_pc),
        .d_pc_next (dec_pc_next),
        .valid     (if_valid),
        .opcode    (if_opcode),
        .rsrc1     (if_rsrc1),
        .rsrc2     (if_rsrc2),
        .rdst      (if_rdst),
        .imm       (if_imm),
        .pc        (if_pc),
        .pc_next   (if_pc_next)
    );

endmodule
